// File: rtl/ps2_key_command_scheduler.sv
// ============================================================================
// ps2_key_command_scheduler
// ----------------------------------------------------------------------------
// Turns the decoded PS/2 byte stream into editor command events. A prefix FSM
// tracks make / break (F0) / extended (E0) sequences and the shift state;
// make codes are mapped to CHAR / ENTER / BKSP and the switch-qualified Enter
// commands (COMPILE, IDLE_MSG, SCROLL_UP, SCROLL_DOWN). Events are queued in a
// small FIFO drained by the text buffer with a valid/ready handshake.
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous active-low reset
//   rx_byte      in   completed scancode byte
//   rx_valid     in   one-cycle strobe, rx_byte valid
//   rx_err       in   one-cycle strobe, receiver framing/parity error
//   sw           in   mode switches {SW15, SW14, SW13, SW12}
//   evt_valid    out  FIFO head valid
//   evt_code     out  0 CHAR,1 ENTER,2 BKSP,3 SCROLL_UP,4 SCROLL_DOWN,
//                     5 COMPILE,6 IDLE_MSG
//   evt_char     out  ASCII for CHAR, 8'h00 otherwise
//   evt_ready    in   consumer accepts the head when evt_valid
//   shift_active out  a shift key is held
//   overflow     out  sticky, an event was dropped on a full FIFO
//   fifo_count   out  number of queued events
// ============================================================================
module ps2_key_command_scheduler #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [7:0]                        rx_byte,
    input  logic                              rx_valid,
    input  logic                              rx_err,
    input  logic [3:0]                        sw,
    output logic                              evt_valid,
    output logic [2:0]                        evt_code,
    output logic [7:0]                        evt_char,
    input  logic                              evt_ready,
    output logic                              shift_active,
    output logic                              overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] EV_CHAR     = 3'd0;
    localparam logic [2:0] EV_ENTER    = 3'd1;
    localparam logic [2:0] EV_BKSP     = 3'd2;
    localparam logic [2:0] EV_SCR_UP   = 3'd3;
    localparam logic [2:0] EV_SCR_DOWN = 3'd4;
    localparam logic [2:0] EV_COMPILE  = 3'd5;
    localparam logic [2:0] EV_IDLE_MSG = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BREAK     = 2'd1,
        ST_EXT       = 2'd2,
        ST_EXT_BREAK = 2'd3
    } state_t;

    // Scancode set 2 to lowercase ASCII; 8'h00 marks an unmapped code.
    function automatic logic [7:0] char_map(input logic [7:0] code);
        logic [7:0] ch;
        case (code)
            8'h1C: ch = 8'h61;  8'h32: ch = 8'h62;  8'h21: ch = 8'h63;
            8'h23: ch = 8'h64;  8'h24: ch = 8'h65;  8'h2B: ch = 8'h66;
            8'h34: ch = 8'h67;  8'h33: ch = 8'h68;  8'h43: ch = 8'h69;
            8'h3B: ch = 8'h6A;  8'h42: ch = 8'h6B;  8'h4B: ch = 8'h6C;
            8'h3A: ch = 8'h6D;  8'h31: ch = 8'h6E;  8'h44: ch = 8'h6F;
            8'h4D: ch = 8'h70;  8'h15: ch = 8'h71;  8'h2D: ch = 8'h72;
            8'h1B: ch = 8'h73;  8'h2C: ch = 8'h74;  8'h3C: ch = 8'h75;
            8'h2A: ch = 8'h76;  8'h1D: ch = 8'h77;  8'h22: ch = 8'h78;
            8'h35: ch = 8'h79;  8'h1A: ch = 8'h7A;
            8'h45: ch = 8'h30;  8'h16: ch = 8'h31;  8'h1E: ch = 8'h32;
            8'h26: ch = 8'h33;  8'h25: ch = 8'h34;  8'h2E: ch = 8'h35;
            8'h36: ch = 8'h36;  8'h3D: ch = 8'h37;  8'h3E: ch = 8'h38;
            8'h46: ch = 8'h39;
            8'h29: ch = 8'h20;  8'h4E: ch = 8'h2D;  8'h55: ch = 8'h3D;
            8'h4C: ch = 8'h3B;  8'h41: ch = 8'h2C;  8'h49: ch = 8'h2E;
            8'h4A: ch = 8'h2F;
            default: ch = 8'h00;
        endcase
        return ch;
    endfunction

    // Enter is re-purposed by the switches, highest switch first.
    function automatic logic [2:0] enter_cmd(input logic [3:0] sws);
        logic [2:0] cmd;
        if (sws[3])      cmd = EV_COMPILE;
        else if (sws[2]) cmd = EV_IDLE_MSG;
        else if (sws[1]) cmd = EV_SCR_UP;
        else if (sws[0]) cmd = EV_SCR_DOWN;
        else             cmd = EV_ENTER;
        return cmd;
    endfunction

    // Make-code decode: returns {push, code[2:0], char[7:0]}.
    function automatic logic [11:0] decode_make(input logic [7:0] code,
                                                input logic       shift,
                                                input logic [3:0] sws);
        logic [7:0]  ch;
        logic [11:0] res;
        ch = char_map(code);
        case (code)
            8'h66:   res = {1'b1, EV_BKSP, 8'h00};
            8'h5A:   res = {1'b1, enter_cmd(sws), 8'h00};
            default: begin
                if (ch == 8'h00) begin
                    res = 12'h000;
                end else if (shift && (ch >= 8'h61) && (ch <= 8'h7A)) begin
                    res = {1'b1, EV_CHAR, ch - 8'h20};
                end else begin
                    res = {1'b1, EV_CHAR, ch};
                end
            end
        endcase
        return res;
    endfunction

    state_t               r_state;
    logic                 r_shift;
    logic [TMO_W-1:0]     r_tmo;

    logic [2:0]           r_mem_code [FIFO_DEPTH];
    logic [7:0]           r_mem_char [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_overflow;
    logic                 r_evt_valid;
    logic [2:0]           r_evt_code;
    logic [7:0]           r_evt_char;

    logic [11:0]          w_dec;
    logic                 w_push;
    logic [2:0]           w_push_code;
    logic [7:0]           w_push_char;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push_ok;
    logic [CNT_W-1:0]     w_count_nxt;
    logic [PTR_W-1:0]     w_rd_nxt;

    assign w_dec = decode_make(rx_byte, r_shift, sw);

    // Event generated by the byte sampled this edge (errors suppress it).
    always_comb begin
        w_push      = 1'b0;
        w_push_code = 3'd0;
        w_push_char = 8'h00;
        if (rx_valid && !rx_err) begin
            case (r_state)
                ST_IDLE: begin
                    {w_push, w_push_code, w_push_char} = w_dec;
                end
                ST_EXT: begin
                    case (rx_byte)
                        8'h75: begin
                            w_push      = 1'b1;
                            w_push_code = EV_SCR_UP;
                        end
                        8'h72: begin
                            w_push      = 1'b1;
                            w_push_code = EV_SCR_DOWN;
                        end
                        // Keypad Enter behaves exactly like the main Enter.
                        8'h5A: begin
                            {w_push, w_push_code, w_push_char} = w_dec;
                        end
                        default: begin
                            w_push = 1'b0;
                        end
                    endcase
                end
                default: begin
                    w_push = 1'b0;
                end
            endcase
        end else begin
            w_push = 1'b0;
        end
    end

    assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop       = (r_count != {CNT_W{1'b0}}) && evt_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_push_ok   = w_push && (!w_full || w_pop);
    assign w_count_nxt = r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);
    assign w_rd_nxt    = w_pop ? (r_rd_ptr + PTR_W'(1)) : r_rd_ptr;

    // Prefix FSM, shift state and prefix timeout.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_shift <= 1'b0;
            r_tmo   <= {TMO_W{1'b0}};
        end else if (rx_err) begin
            r_state <= ST_IDLE;
            r_tmo   <= {TMO_W{1'b0}};
        end else if (rx_valid) begin
            r_tmo <= {TMO_W{1'b0}};
            case (r_state)
                ST_IDLE: begin
                    if (rx_byte == 8'hF0) begin
                        r_state <= ST_BREAK;
                    end else if (rx_byte == 8'hE0) begin
                        r_state <= ST_EXT;
                    end else begin
                        r_state <= ST_IDLE;
                        if ((rx_byte == 8'h12) || (rx_byte == 8'h59)) begin
                            r_shift <= 1'b1;
                        end
                    end
                end
                ST_BREAK: begin
                    if ((rx_byte == 8'h12) || (rx_byte == 8'h59)) begin
                        r_shift <= 1'b0;
                    end
                    r_state <= ST_IDLE;
                end
                ST_EXT: begin
                    r_state <= (rx_byte == 8'hF0) ? ST_EXT_BREAK : ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end else if (r_state != ST_IDLE) begin
            // An abandoned prefix must not swallow the next make code.
            if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                r_state <= ST_IDLE;
                r_tmo   <= {TMO_W{1'b0}};
            end else begin
                r_tmo <= r_tmo + TMO_W'(1);
            end
        end else begin
            r_tmo <= {TMO_W{1'b0}};
        end
    end

    // Event storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem_code[r_wr_ptr] <= w_push_code;
            r_mem_char[r_wr_ptr] <= w_push_char;
        end
    end

    // FIFO pointers, count, overflow and the registered head outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr    <= {PTR_W{1'b0}};
            r_rd_ptr    <= {PTR_W{1'b0}};
            r_count     <= {CNT_W{1'b0}};
            r_overflow  <= 1'b0;
            r_evt_valid <= 1'b0;
            r_evt_code  <= 3'd0;
            r_evt_char  <= 8'h00;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
            r_rd_ptr <= w_rd_nxt;
            r_count  <= w_count_nxt;
            // The new head is the entry being written this edge when it lands
            // at the next read slot; otherwise it is already in storage.
            if (w_count_nxt == {CNT_W{1'b0}}) begin
                r_evt_valid <= 1'b0;
                r_evt_code  <= 3'd0;
                r_evt_char  <= 8'h00;
            end else if (w_push_ok && (r_wr_ptr == w_rd_nxt)) begin
                r_evt_valid <= 1'b1;
                r_evt_code  <= w_push_code;
                r_evt_char  <= w_push_char;
            end else begin
                r_evt_valid <= 1'b1;
                r_evt_code  <= r_mem_code[w_rd_nxt];
                r_evt_char  <= r_mem_char[w_rd_nxt];
            end
        end
    end

    assign evt_valid    = r_evt_valid;
    assign evt_code     = r_evt_code;
    assign evt_char     = r_evt_char;
    assign shift_active = r_shift;
    assign overflow     = r_overflow;
    assign fifo_count   = r_count;

endmodule

// File: doc/ps2_key_command_scheduler.md
# ps2_key_command_scheduler

Sequences the decoded PS/2 byte stream from the keyboard receiver into editor commands for the display/text-buffer path. Tracks make/break/extended prefixes and shift state, applies the switch-qualified Enter commands (compile, idle message, scroll), and queues the resulting events in a small FIFO drained by the text buffer with a valid/ready handshake. It sits between the byte-level PS/2 receiver and the text buffer / message controller.

## Interface
- `FIFO_DEPTH`, 4: event FIFO entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, 2_500_000: idle cycles after which a pending prefix is abandoned.

- `clk` in 1: system clock.
- `rst` in 1: reset; one clock; reset is synchronous and active-low (`rst`=0 resets on the next `clk` edge).
- `rx_byte` in 8: completed scancode byte from the receiver.
- `rx_valid` in 1: single-cycle strobe, `rx_byte` valid.
- `rx_err` in 1: single-cycle strobe, receiver framing/parity error.
- `sw` in 4: mode switches; `sw[3]`=SW15, `sw[2]`=SW14, `sw[1]`=SW13, `sw[0]`=SW12.
- `evt_valid` out 1: FIFO head valid.
- `evt_code` out 3: 0 CHAR, 1 ENTER, 2 BKSP, 3 SCROLL_UP, 4 SCROLL_DOWN, 5 COMPILE, 6 IDLE_MSG.
- `evt_char` out 8: ASCII for CHAR, 8'h00 otherwise.
- `evt_ready` in 1: consumer accepts head when `evt_valid`.
- `shift_active` out 1: a shift key is held.
- `overflow` out 1: sticky, an event was dropped on a full FIFO.
- `fifo_count` out $clog2(FIFO_DEPTH+1): entries held.

## Operation
- Prefix FSM, updated on `rx_valid` edges only:
  - IDLE: F0→BREAK; E0→EXT; other byte = make code, decoded, stay IDLE.
  - BREAK: byte is a release; 12 or 59 clears shift; no event; →IDLE.
  - EXT: F0→EXT_BREAK; 75→SCROLL_UP; 72→SCROLL_DOWN; 5A→keypad Enter (same as 5A make); other bytes ignored; →IDLE.
  - EXT_BREAK: any byte, no event, →IDLE.
- Make decode: 12/59 set shift, no event. 66→BKSP. 5A→ by priority `sw[3]` COMPILE, `sw[2]` IDLE_MSG, `sw[1]` SCROLL_UP, `sw[0]` SCROLL_DOWN, else ENTER; `sw` sampled the same edge.
- CHAR map (lowercase, shift→uppercase letters only): 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z; 45 '0', 16 '1', 1E '2', 26 '3', 25 '4', 2E '5', 36 '6', 3D '7', 3E '8', 46 '9'; 29 space, 4E '-', 55 '=', 4C ';', 41 ',', 49 '.', 4A '/'. Unmapped make codes: no event.
- Typematic repeats (same make code without release) each produce an event.
- `rx_err`: FSM→IDLE, pending prefix discarded, no event, shift unchanged. `rx_err` and `rx_valid` together: error wins, byte ignored.
- Timeout: counter runs while FSM ≠ IDLE, cleared on every `rx_valid`; at `TIMEOUT_CYCLES` FSM→IDLE, no event.
- FIFO: push on the decoding edge; pop when `evt_valid && evt_ready`. Full with push and no pop: event dropped, `overflow`←1 (cleared only by reset). Full with push and pop same edge: both occur, count unchanged. Pop on empty: ignored.

## Timing
- Reset: FSM IDLE, shift 0, FIFO empty, `evt_valid`=0, `evt_code`=0, `evt_char`=0, `shift_active`=0, `overflow`=0, `fifo_count`=0, timeout counter 0. Reset mid-sequence discards all state and queued events.
- Latency: `rx_valid` sampled at edge N → event visible (`evt_valid`=1 if FIFO was empty) in the cycle after N.
- `shift_active` updates the cycle after the shift make/break edge; a letter strobed one cycle after shift make is uppercase.
- `evt_code`/`evt_char` held stable while `evt_valid && !evt_ready`.
- `fifo_count` reflects push/pop of the preceding edge; at most one push and one pop per cycle.

## Test plan
- Bytes 1C, F0, 1C, `sw`=0 → one event CHAR 8'h61; no event from the release; FSM back in IDLE.
- 12, 1C, F0, 12, 1C → CHAR 8'h41 then CHAR 8'h61; `shift_active` 1 then 0.
- 5A with `sw`=4'b1010 → COMPILE; `sw`=4'b0001 → SCROLL_DOWN; `sw`=0 → ENTER; E0 75 → SCROLL_UP; E0 F0 75 → no event.
- `evt_ready`=0, five make codes 16, 1E, 26, 25, 2E with `FIFO_DEPTH`=4 → `fifo_count`=4, `overflow`=1; draining yields '1','2','3','4' in order.
- E0 then `rx_err` → no event, next byte 1C yields CHAR 'a'; F0 then `TIMEOUT_CYCLES` idle then 1C → CHAR 'a' (not treated as a release).
- `rst`=0 with 3 queued events and FSM in BREAK → next cycle `evt_valid`=0, `fifo_count`=0, `overflow`=0, next 1C yields CHAR 'a'.
